// File: rtl/debounced_accum_calc.sv
// Keypad calculator core with button conditioning.
// Each raw button passes through a 2-FF synchroniser and a stability-count
// debouncer; the debounced rising edge becomes a one-cycle pulse.
// Load pulses push zero-extended key_pad values into a bounded operand
// buffer. A sum pulse walks the buffer one operand per cycle and adds or
// subtracts them.
// Ports:
//   sys_clk, sys_rst       clock, async active-high reset
//   load/sum/clr_button    raw async push-buttons
//   sub_mode               0=add, 1=subtract (latched on accepted sum)
//   key_pad                operand (latched on accepted load)
//   result, result_valid   accumulator output and its valid flag
//   op_count               operands held in the buffer
//   busy                   accumulation in progress
//   overflow, load_err     sticky carry/borrow and buffer-full flags

// One conditioned button: synchroniser -> debouncer -> rising-edge pulse.
module btn_cond #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pulse
);
  localparam int CW = $clog2(DEB_CYCLES);

  logic [1:0]    sync_q;
  logic          level_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      pulse   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw};
      pulse  <= 1'b0;
      // Level flips only after DEB_CYCLES consecutive mismatching samples;
      // any agreeing sample restarts the count.
      if (sync_q[1] != level_q) begin
        if (cnt_q == CW'(DEB_CYCLES - 1)) begin
          level_q <= sync_q[1];
          cnt_q   <= '0;
          pulse   <= sync_q[1];
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end
endmodule

module debounced_accum_calc #(
  parameter int DIGIT_W    = 4,
  parameter int NUM_OPS    = 4,
  parameter int ACC_W      = 8,
  parameter int DEB_CYCLES = 4
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst,
  input  logic                         load_button,
  input  logic                         sum_button,
  input  logic                         clr_button,
  input  logic                         sub_mode,
  input  logic [DIGIT_W-1:0]           key_pad,
  output logic [ACC_W-1:0]             result,
  output logic                         result_valid,
  output logic [$clog2(NUM_OPS+1)-1:0] op_count,
  output logic                         busy,
  output logic                         overflow,
  output logic                         load_err
);
  localparam int CNT_W = $clog2(NUM_OPS+1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  // Button index: 0=load, 1=sum, 2=clr
  logic [2:0] raw_btn, btn_pulse;
  assign raw_btn = {clr_button, sum_button, load_button};

  for (genvar b = 0; b < 3; b++) begin : g_btn
    btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_btn (
      .clk   (sys_clk),
      .rst   (sys_rst),
      .raw   (raw_btn[b]),
      .pulse (btn_pulse[b])
    );
  end

  logic load_p, sum_p, clr_p;
  assign load_p = btn_pulse[0];
  assign sum_p  = btn_pulse[1];
  assign clr_p  = btn_pulse[2];

  state_t                         state_q, state_d;
  logic [NUM_OPS-1:0][ACC_W-1:0]  op_buf;
  logic [ACC_W-1:0]               acc_q;
  logic [CNT_W-1:0]               idx_q;
  logic                           mode_q;
  logic                           do_load, do_sum, acc_step;
  logic [ACC_W-1:0]               cur_op, acc_nxt;
  logic                           ovf_nxt;
  logic [ACC_W:0]                 sum_w, diff_w;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state and per-cycle actions; clr outranks sum outranks load.
  always_comb begin
    state_d  = state_q;
    do_load  = 1'b0;
    do_sum   = 1'b0;
    acc_step = 1'b0;
    if (clr_p) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (sum_p) begin
            do_sum  = 1'b1;
            state_d = ACCUM;
          end else if (load_p) begin
            do_load = 1'b1;
          end
        end
        ACCUM: begin
          acc_step = 1'b1;
          if (op_count == '0 || idx_q == op_count - CNT_W'(1)) state_d = DONE;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign busy = (state_q == ACCUM);

  // Operand mux and one accumulation step.
  always_comb begin
    cur_op = '0;
    for (int i = 0; i < NUM_OPS; i++)
      if (idx_q == CNT_W'(i)) cur_op = op_buf[i];
    sum_w  = {1'b0, acc_q} + {1'b0, cur_op};
    diff_w = {1'b0, acc_q} - {1'b0, cur_op};
    if (!mode_q) begin
      acc_nxt = sum_w[ACC_W-1:0];
      ovf_nxt = sum_w[ACC_W];
    end else if (idx_q == '0) begin
      // Subtraction starts from the first operand, not from zero.
      acc_nxt = cur_op;
      ovf_nxt = 1'b0;
    end else begin
      acc_nxt = diff_w[ACC_W-1:0];
      ovf_nxt = diff_w[ACC_W];
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      op_buf       <= '0;
      op_count     <= '0;
      acc_q        <= '0;
      idx_q        <= '0;
      mode_q       <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      overflow     <= 1'b0;
      load_err     <= 1'b0;
    end else if (clr_p) begin
      op_buf       <= '0;
      op_count     <= '0;
      acc_q        <= '0;
      idx_q        <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      overflow     <= 1'b0;
      load_err     <= 1'b0;
    end else begin
      if (do_load) begin
        if (op_count < CNT_W'(NUM_OPS)) begin
          for (int i = 0; i < NUM_OPS; i++)
            if (op_count == CNT_W'(i)) op_buf[i] <= ACC_W'(key_pad);
          op_count     <= op_count + CNT_W'(1);
          result_valid <= 1'b0;
        end else begin
          load_err <= 1'b1;
        end
      end
      if (do_sum) begin
        mode_q   <= sub_mode;
        acc_q    <= '0;
        idx_q    <= '0;
        overflow <= 1'b0;
      end
      if (acc_step && op_count != '0) begin
        acc_q <= acc_nxt;
        idx_q <= idx_q + CNT_W'(1);
        if (ovf_nxt) overflow <= 1'b1;
      end
      // result only moves here, so a partial sum is never exposed.
      if (state_q == DONE) begin
        result       <= acc_q;
        result_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_debounced_accum_calc.sv
module tb_debounced_accum_calc;
  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       load_button = 1'b0, sum_button = 1'b0, clr_button = 1'b0;
  logic       sub_mode = 1'b0;
  logic [3:0] key_pad = '0;
  logic [7:0] result;
  logic       result_valid;
  logic [2:0] op_count;
  logic       busy, overflow, load_err;

  debounced_accum_calc #(.DIGIT_W(4), .NUM_OPS(4), .ACC_W(8), .DEB_CYCLES(4)) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .load_button  (load_button),
    .sum_button   (sum_button),
    .clr_button   (clr_button),
    .sub_mode     (sub_mode),
    .key_pad      (key_pad),
    .result       (result),
    .result_valid (result_valid),
    .op_count     (op_count),
    .busy         (busy),
    .overflow     (overflow),
    .load_err     (load_err)
  );

  always #5 sys_clk = ~sys_clk;

  int tests = 0;
  int fails = 0;
  int busy_cnt;
  int valid_seen;

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input int res, input int vld,
                           input int cnt, input int ovf, input int err);
    check({tag, ".result"},       int'(result),       res);
    check({tag, ".result_valid"}, int'(result_valid), vld);
    check({tag, ".op_count"},     int'(op_count),     cnt);
    check({tag, ".overflow"},     int'(overflow),     ovf);
    check({tag, ".load_err"},     int'(load_err),     err);
  endtask

  // Hold the chosen buttons clean for 8 cycles, release, let everything settle.
  task automatic press(input logic l, input logic s, input logic c,
                       input logic [3:0] k, input logic sm);
    key_pad = k; sub_mode = sm;
    busy_cnt = 0; valid_seen = 0;
    load_button = l; sum_button = s; clr_button = c;
    repeat (8) begin
      @(negedge sys_clk);
      if (busy) busy_cnt++;
    end
    load_button = 1'b0; sum_button = 1'b0; clr_button = 1'b0;
    repeat (16) begin
      @(negedge sys_clk);
      if (busy) busy_cnt++;
    end
  endtask

  // Reference model: operand list plus flags, evaluated with plain arithmetic.
  int mq[$];
  int m_res, m_vld, m_ovf, m_err, m_busy;

  task automatic model_clear();
    mq.delete();
    m_res = 0; m_vld = 0; m_ovf = 0; m_err = 0; m_busy = 0;
  endtask

  task automatic model_op(input int kind, input int key, input int sub);
    int acc;
    m_busy = 0;
    if (kind == 2) begin
      mq.delete();
      m_res = 0; m_vld = 0; m_ovf = 0; m_err = 0;
    end else if (kind == 1) begin
      m_ovf = 0;
      m_busy = (mq.size() > 0) ? mq.size() : 1;
      if (mq.size() == 0) acc = 0;
      else if (sub == 0) begin
        acc = 0;
        foreach (mq[i]) begin
          acc += mq[i];
          if (acc > 255) begin m_ovf = 1; acc -= 256; end
        end
      end else begin
        acc = mq[0];
        for (int i = 1; i < mq.size(); i++) begin
          acc -= mq[i];
          if (acc < 0) begin m_ovf = 1; acc += 256; end
        end
      end
      m_res = acc; m_vld = 1;
    end else begin
      if (mq.size() < 4) begin mq.push_back(key); m_vld = 0; end
      else m_err = 1;
    end
  endtask

  typedef struct {
    int kind;  // 0 load, 1 sum, 2 clr
    int key;
    int sub;
    int res, vld, cnt, ovf, err, bsy;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int lat;
    int kind, key, sub;

    tbl[0]  = '{0, 7, 0,   0, 0, 1, 0, 0, 0};
    tbl[1]  = '{0, 9, 0,   0, 0, 2, 0, 0, 0};
    tbl[2]  = '{1, 0, 0,  16, 1, 2, 0, 0, 2};
    tbl[3]  = '{2, 0, 0,   0, 0, 0, 0, 0, 0};
    tbl[4]  = '{0, 3, 0,   0, 0, 1, 0, 0, 0};
    tbl[5]  = '{0, 9, 0,   0, 0, 2, 0, 0, 0};
    tbl[6]  = '{1, 0, 1, 250, 1, 2, 1, 0, 2};
    tbl[7]  = '{1, 0, 0,  12, 1, 2, 0, 0, 2};
    tbl[8]  = '{2, 0, 0,   0, 0, 0, 0, 0, 0};
    tbl[9]  = '{0, 15, 0,  0, 0, 1, 0, 0, 0};
    tbl[10] = '{0, 15, 0,  0, 0, 2, 0, 0, 0};
    tbl[11] = '{0, 15, 0,  0, 0, 3, 0, 0, 0};
    tbl[12] = '{0, 15, 0,  0, 0, 4, 0, 0, 0};
    tbl[13] = '{0, 15, 0,  0, 0, 4, 0, 1, 0};
    tbl[14] = '{1, 0, 0,  60, 1, 4, 0, 1, 4};
    tbl[15] = '{2, 0, 0,   0, 0, 0, 0, 0, 0};

    // Reset state
    repeat (3) @(negedge sys_clk);
    check_all("reset", 0, 0, 0, 0, 0);
    check("reset.busy", int'(busy), 0);
    sys_rst = 1'b0;
    repeat (2) @(negedge sys_clk);

    // Bounce rejection: toggling every cycle never stays stable long enough
    for (int i = 0; i < 10; i++) begin
      load_button = ~load_button;
      @(negedge sys_clk);
    end
    load_button = 1'b0;
    repeat (20) @(negedge sys_clk);
    check("bounce.op_count", int'(op_count), 0);

    // Directed vector table
    for (int i = 0; i < 16; i++) begin
      press(tbl[i].kind == 0, tbl[i].kind == 1, tbl[i].kind == 2,
            4'(tbl[i].key), tbl[i].sub[0]);
      check_all($sformatf("tbl%0d", i), tbl[i].res, tbl[i].vld, tbl[i].cnt,
                tbl[i].ovf, tbl[i].err);
      check($sformatf("tbl%0d.busy_cycles", i), busy_cnt, tbl[i].bsy);
    end

    // Empty sum: latency from raw press to result_valid
    sum_button = 1'b1;
    lat = 0;
    while (!result_valid && lat < 30) begin
      @(negedge sys_clk);
      lat++;
    end
    check("empty_sum.latency", lat, 9);
    check("empty_sum.result", int'(result), 0);
    sum_button = 1'b0;
    repeat (16) @(negedge sys_clk);

    // clr and sum together: clear wins, no accumulation
    press(1'b1, 1'b0, 1'b0, 4'd5, 1'b0);
    check("prio.preload_cnt", int'(op_count), 1);
    press(1'b0, 1'b1, 1'b1, 4'd0, 1'b0);
    check("prio.busy_cycles", busy_cnt, 0);
    check_all("prio", 0, 0, 0, 0, 0);

    // clr arriving two cycles after sum aborts the 4-operand accumulation
    for (int i = 0; i < 4; i++) press(1'b1, 1'b0, 1'b0, 4'd10, 1'b0);
    busy_cnt = 0; valid_seen = 0;
    sum_button = 1'b1;
    repeat (2) @(negedge sys_clk);
    clr_button = 1'b1;
    repeat (20) begin
      @(negedge sys_clk);
      if (busy) busy_cnt++;
      if (result_valid) valid_seen++;
    end
    sum_button = 1'b0; clr_button = 1'b0;
    repeat (16) @(negedge sys_clk);
    check("abort.busy_cycles", busy_cnt, 2);
    check("abort.valid_seen", valid_seen, 0);
    check_all("abort", 0, 0, 0, 0, 0);
    check("abort.busy", int'(busy), 0);

    // Async reset mid-accumulation
    for (int i = 0; i < 4; i++) press(1'b1, 1'b0, 1'b0, 4'd15, 1'b0);
    press(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    check("arst.pre_result", int'(result), 60);
    sum_button = 1'b1;
    lat = 0;
    while (!busy && lat < 20) begin
      @(negedge sys_clk);
      lat++;
    end
    check("arst.busy_seen", int'(busy), 1);
    #2 sys_rst = 1'b1;
    #1;
    check_all("arst", 0, 0, 0, 0, 0);
    check("arst.busy", int'(busy), 0);
    sum_button = 1'b0;
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (4) @(negedge sys_clk);
    check_all("arst_after", 0, 0, 0, 0, 0);

    // Randomized operations against the reference model
    model_clear();
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 9);
      kind = (kind < 5) ? 0 : (kind < 8) ? 1 : 2;
      key  = $urandom_range(0, 15);
      sub  = $urandom_range(0, 1);
      model_op(kind, key, sub);
      press(kind == 0, kind == 1, kind == 2, 4'(key), sub[0]);
      check_all($sformatf("rnd%0d", n), m_res, m_vld, mq.size(), m_ovf, m_err);
      check($sformatf("rnd%0d.busy_cycles", n), busy_cnt, m_busy);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/debounced_accum_calc.md
Name: debounced_accum_calc

Overview:
Parametrised successor to the board-level keypad calculator core. Conditions three raw push-buttons (load, sum, clear) through synchronisers and stability-count debouncers. Loads keypad operands into a bounded operand buffer and, on sum, accumulates them sequentially in add or subtract mode. Sits between the keypad/button pins and the seven-segment display driver, which consumes `result`.

Parameters:
DIGIT_W, 4, width of one keypad operand (unsigned)
NUM_OPS, 4, operand buffer depth (>=1)
ACC_W, 8, accumulator/result width (>= DIGIT_W+1)
DEB_CYCLES, 4, consecutive stable synchronised samples required to change a debounced level (>=2)

Ports:
sys_clk  in  1  system clock, all logic rising-edge
sys_rst  in  1  asynchronous active-high reset
load_button  in  1  raw, bouncy, async
sum_button  in  1  raw, bouncy, async
clr_button  in  1  raw, bouncy, async
sub_mode  in  1  0=add, 1=subtract; sampled when a sum pulse is accepted
key_pad  in  DIGIT_W  operand value; sampled on accepted load pulse
result  out  ACC_W  accumulator value
result_valid  out  1  high from end of accumulation until next accepted load/clr
op_count  out  clog2(NUM_OPS+1)  operands currently held
busy  out  1  high while in ACCUM
overflow  out  1  sticky: carry/borrow out of ACC_W during current sum
load_err  out  1  sticky: load attempted while buffer full

Behaviour:
- Reset (async assert, sync release): all outputs 0; buffer, debounce counters, synchronisers, debounced levels cleared; FSM=IDLE.
- Conditioning per button: 2-FF synchroniser -> debouncer. Debounced level changes only after the synchronised value differs from it for DEB_CYCLES consecutive cycles; any mismatch break resets the count. One-cycle pulse on each debounced 0->1; no pulse on release.
- Pulse latency: raw rise held clean -> pulse in cycle 2+DEB_CYCLES after the first sampling edge. Glitches shorter than DEB_CYCLES cycles produce no pulse.
- Pulse priority, same cycle: clr > sum > load; lower-priority pulses are dropped.
- FSM states:
  - IDLE: load pulse with op_count<NUM_OPS -> buf[op_count]<=zero-extended key_pad, op_count++, result_valid<=0. Load pulse with op_count==NUM_OPS -> buffer unchanged, load_err<=1. Sum pulse -> latch sub_mode, acc<=0, overflow<=0, idx<=0, go to ACCUM (op_count==0 still goes via ACCUM).
  - ACCUM: busy=1; processes one operand per cycle.
    - Add mode: acc += buf[idx].
    - Subtract mode: idx 0 loads acc<=buf[0]; later operands acc -= buf[idx].
    - Carry (add) or borrow (sub) out of ACC_W sets overflow; result wraps mod 2^ACC_W.
    - After idx==op_count-1, or immediately if op_count==0, go to DONE.
    - Load and sum pulses ignored; clr honoured.
  - DONE (1 cycle): result<=acc, result_valid<=1, go to IDLE. Buffer and op_count retained, so a repeat sum recomputes.
- Sum latency: accepted pulse at cycle T -> result_valid rises at T+max(op_count,1)+2.
- clr pulse in any state: buffer, op_count, result, result_valid, overflow, load_err <=0; FSM->IDLE next cycle; aborts ACCUM.
- sys_rst mid-ACCUM: immediate return to reset state; no partial result visible.
- `result` holds its last value until DONE or clr; it is never updated mid-accumulation.

Test Plan:
- Bounce reject (DEB_CYCLES=4): load_button toggles 1/0 every cycle for 10 cycles, then held 0 -> no load pulse, op_count stays 0.
- Clean add: load 7, load 9 (each held 8 cycles), sum with sub_mode=0 -> busy 2 cycles, result=16 (0x10), result_valid=1, overflow=0, op_count=2.
- Subtract wrap: load 3, load 9, sum with sub_mode=1 -> result=0xFA, overflow=1; then sum with sub_mode=0 on the same buffer -> result=12, overflow=0.
- Full buffer (NUM_OPS=4): five loads of 15 -> op_count=4, load_err=1; sum -> result=60, overflow=0.
- Priority/abort: clr and sum pulses in the same cycle -> clear wins, busy never asserts. Separately, clr mid-ACCUM -> all outputs 0, FSM=IDLE.
- Empty sum plus async reset: sum with op_count=0 -> result=0, result_valid=1 after 3 cycles. sys_rst pulse asserted mid-clock during ACCUM -> outputs 0 before the next edge.
